// File: rtl/io_port_bank_if.sv
// Core-side IN/OUT bus of the I/O port bank.
// Read data returns one cycle after the strobe, qualified by rd_valid.
interface io_port_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output rd_en, wr_en, addr, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/io_port_bank.sv
// External I/O port bank: synchronised inputs, change flags, registered outputs.
// Define IO_CHG_IRQ_EN to add the MASK register and the change interrupt.
module io_port_bank #(
  parameter int              DATA_W    = 8,
  parameter int              N_PORTS   = 4,
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PORT_BASE = '0
) (
  input  logic                      clk,
  input  logic                      Reset,
  io_port_bank_if.slave             bus,
  input  logic [N_PORTS*DATA_W-1:0] ext_in,
  output logic [N_PORTS*DATA_W-1:0] ext_out,
  output logic [N_PORTS-1:0]        chg_pending,
  output logic                      irq
);

  localparam logic [ADDR_W-1:0] STAT_OFF = ADDR_W'(N_PORTS);
  localparam logic [ADDR_W-1:0] MASK_OFF = ADDR_W'(N_PORTS + 1);

  logic [ADDR_W-1:0]  off;
  logic [DATA_W-1:0]  s1 [N_PORTS];
  logic [DATA_W-1:0]  s2 [N_PORTS];
  logic [DATA_W-1:0]  s3 [N_PORTS];
  logic [1:0]         warm;
  logic               warm_done;
  logic [N_PORTS-1:0] port_sel;
  logic [N_PORTS-1:0] chg_set;
  logic               stat_sel;
  logic               mask_sel;
  logic               stat_rd;
  logic [DATA_W-1:0]  mask_rd;
  logic [DATA_W-1:0]  rd_mux;

  // Offset wraps modulo 2^ADDR_W, so addresses below PORT_BASE fall unmapped.
  assign off       = bus.addr - PORT_BASE;
  assign stat_sel  = (off == STAT_OFF);
  assign mask_sel  = (off == MASK_OFF);
  assign stat_rd   = bus.rd_en && stat_sel;
  assign warm_done = (warm == 2'd3);

  always_comb begin
    port_sel = '0;
    chg_set  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      port_sel[i] = (off == ADDR_W'(i));
      chg_set[i]  = warm_done && (s2[i] != s3[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (port_sel[i]) rd_mux = s2[i];
    end
    if (stat_sel) rd_mux = DATA_W'(chg_pending);
    if (mask_sel) rd_mux = mask_rd;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      warm         <= '0;
      ext_out      <= '0;
      chg_pending  <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        s1[i] <= '0;
        s2[i] <= '0;
        s3[i] <= '0;
      end
    end else begin
      if (!warm_done) warm <= warm + 2'd1;
      for (int i = 0; i < N_PORTS; i++) begin
        s1[i] <= ext_in[i*DATA_W +: DATA_W];
        s2[i] <= s1[i];
        s3[i] <= s2[i];
        if (bus.wr_en && port_sel[i])
          ext_out[i*DATA_W +: DATA_W] <= bus.wr_data;
      end
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
      // A fresh change on the read edge survives the clear.
      chg_pending <= (stat_rd ? '0 : chg_pending) | chg_set;
    end
  end

`ifdef IO_CHG_IRQ_EN
  logic [N_PORTS-1:0] mask_q;

  assign mask_rd = DATA_W'(mask_q);

  always_ff @(posedge clk) begin
    if (Reset) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (bus.wr_en && mask_sel)
        mask_q <= bus.wr_data[N_PORTS-1:0];
      irq <= |(chg_pending & mask_q);
    end
  end
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

endmodule
